// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle ARM shifter-operand sequencer.
// Latches an instruction on start, decodes the shifter operation in LOAD, and
// iterates the shift STEP bits per cycle before presenting result/cout on done.
// Optional feature macro: SHIFT_BY_REG_EN enables register-specified shift
// amounts (instr[27:25]=000 with instr[4]=1, amount from rs_val[7:0]).
module shift_sequencer #(
  parameter int STEP  = 1,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] rm_val,
  input  logic [31:0] rs_val,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cout
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(32);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_LSL,
    OP_LSR,
    OP_ASR,
    OP_ROR,
    OP_RRX
  } op_t;

  state_t state_q, state_d;

  // Captured request
  logic [2:0]  cls_q;
  logic [11:0] imm_q;
  logic [31:0] a_q;
  logic        cin_q;
  logic [7:0]  ramt;
  logic        use_reg;

  // Decode results (valid in LOAD)
  logic [31:0]      ld_w;
  logic             ld_c;
  logic [CNT_W-1:0] ld_n;
  op_t              ld_op;

  // Working state
  logic [31:0]      w_q;
  logic             c_q;
  op_t              op_q;
  logic [CNT_W-1:0] rem_q;

  // One shift step
  logic [CNT_W-1:0] s_amt;
  logic [CNT_W-1:0] rem_next;
  logic [31:0]      st_w;
  logic             st_c;

  logic [4:0] amt;
  logic [1:0] sh;
  logic       shift_form;
  logic       unused_bits;

`ifdef SHIFT_BY_REG_EN
  logic [7:0] rs_q;
  assign ramt        = rs_q;
  assign use_reg     = (cls_q == 3'b000) && imm_q[4];
  assign unused_bits = ^{instr[31:28], instr[24:12], rs_val[31:8]};
`else
  assign ramt        = 8'd0;
  assign use_reg     = 1'b0;
  assign unused_bits = ^{instr[31:28], instr[24:12], rs_val};
`endif

  assign amt        = imm_q[11:7];
  assign sh         = imm_q[6:5];
  assign shift_form = (cls_q == 3'b000) ||
                      ((cls_q == 3'b011) && (imm_q[11:4] != 8'd0));

  // Applies up to STEP single-bit shifts; carry always holds the last bit out.
  function automatic logic [32:0] shift_bits(input logic [31:0]      w,
                                             input logic             c,
                                             input op_t              op,
                                             input logic [CNT_W-1:0] s);
    logic [31:0]        r;
    logic               rc;
    logic               lsb;
    logic signed [31:0] sw;
    r   = w;
    rc  = c;
    lsb = 1'b0;
    sw  = '0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(s)) begin
        case (op)
          OP_LSL: begin
            rc = r[31];
            r  = {r[30:0], 1'b0};
          end
          OP_LSR: begin
            rc = r[0];
            r  = {1'b0, r[31:1]};
          end
          OP_ASR: begin
            rc = r[0];
            sw = r;
            r  = sw >>> 1;
          end
          OP_ROR: begin
            r  = {r[0], r[31:1]};
            rc = r[31];
          end
          default: begin
            lsb = r[0];
            r   = {rc, r[31:1]};
            rc  = lsb;
          end
        endcase
      end
    end
    return {rc, r};
  endfunction

  // Decode the captured instruction into working value, carry, op and count.
  // The #0 encodings of LSR/ASR resolve here without iterating.
  always_comb begin
    ld_w  = a_q;
    ld_c  = cin_q;
    ld_n  = '0;
    ld_op = OP_LSL;
    if (shift_form && use_reg) begin
      if (ramt != 8'd0) begin
        case (sh)
          2'b00, 2'b01: begin
            ld_op = (sh == 2'b00) ? OP_LSL : OP_LSR;
            if (ramt > 8'd32) begin
              ld_w = '0;
              ld_c = 1'b0;
              ld_n = FULL_C;
            end else begin
              ld_n = CNT_W'(ramt);
            end
          end
          2'b10: begin
            ld_op = OP_ASR;
            ld_n  = (ramt >= 8'd32) ? FULL_C : CNT_W'(ramt);
          end
          default: begin
            ld_op = OP_ROR;
            if (ramt[4:0] == 5'd0) begin
              ld_c = a_q[31];
            end else begin
              ld_n = CNT_W'(ramt[4:0]);
            end
          end
        endcase
      end
    end else if (shift_form) begin
      case (sh)
        2'b00: begin
          ld_op = OP_LSL;
          ld_n  = CNT_W'(amt);
        end
        2'b01: begin
          ld_op = OP_LSR;
          if (amt == 5'd0) begin
            ld_w = '0;
            ld_c = a_q[31];
          end else begin
            ld_n = CNT_W'(amt);
          end
        end
        2'b10: begin
          ld_op = OP_ASR;
          if (amt == 5'd0) begin
            ld_w = {32{a_q[31]}};
            ld_c = a_q[31];
          end else begin
            ld_n = CNT_W'(amt);
          end
        end
        default: begin
          if (amt == 5'd0) begin
            ld_op = OP_RRX;
            ld_n  = CNT_W'(1);
          end else begin
            ld_op = OP_ROR;
            ld_n  = CNT_W'(amt);
          end
        end
      endcase
    end else if (cls_q == 3'b001) begin
      ld_w  = {24'b0, imm_q[7:0]};
      ld_op = OP_ROR;
      ld_n  = CNT_W'({imm_q[11:8], 1'b0});
    end else if (cls_q == 3'b010) begin
      ld_w = {20'b0, imm_q};
    end
  end

  // One iteration: shift by min(STEP, remaining) and update the count.
  always_comb begin
    s_amt        = (rem_q < STEP_C) ? rem_q : STEP_C;
    {st_c, st_w} = shift_bits(w_q, c_q, op_q, s_amt);
    rem_next     = rem_q - s_amt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = (ld_n == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (rem_next == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Remaining-shift counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else if (state_q == S_LOAD) begin
      rem_q <= ld_n;
    end else if (state_q == S_SHIFT) begin
      rem_q <= rem_next;
    end
  end

  // Result and carry are written on the edge into DONE and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
    end else if (state_q == S_LOAD && ld_n == '0) begin
      result <= ld_w;
      cout   <= ld_c;
    end else if (state_q == S_SHIFT && rem_next == '0) begin
      result <= st_w;
      cout   <= st_c;
    end
  end

  // Request capture and working register; contents only matter while busy.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      cls_q <= instr[27:25];
      imm_q <= instr[11:0];
      a_q   <= rm_val;
      cin_q <= cin;
`ifdef SHIFT_BY_REG_EN
      rs_q  <= rs_val[7:0];
`endif
    end
    if (state_q == S_LOAD) begin
      w_q  <= ld_w;
      c_q  <= ld_c;
      op_q <= ld_op;
    end else if (state_q == S_SHIFT) begin
      w_q <= st_w;
      c_q <= st_c;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized self-checking bench for shift_sequencer.
// Drives two instances (STEP=1 and STEP=4) with identical requests and checks
// both against a whole-shift reference model. Honors SHIFT_BY_REG_EN.
module tb_shift_sequencer;

`ifdef SHIFT_BY_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] instr;
  logic [31:0] rm_val;
  logic [31:0] rs_val;
  logic        cin;
  logic        busy1, done1, cout1;
  logic [31:0] res1;
  logic        busy4, done4, cout4;
  logic [31:0] res4;

  int n_tests = 0;
  int n_fail  = 0;
  int op_id   = 0;

  shift_sequencer #(.STEP(1), .CNT_W(6)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .rm_val(rm_val),
    .rs_val(rs_val), .cin(cin), .busy(busy1), .done(done1), .result(res1),
    .cout(cout1)
  );

  shift_sequencer #(.STEP(4), .CNT_W(6)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .rm_val(rm_val),
    .rs_val(rs_val), .cin(cin), .busy(busy4), .done(done4), .result(res4),
    .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (op %0d): got 0x%0h expected 0x%0h", tag, op_id, got, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int k);
    int m;
    m = k % 32;
    if (m == 0) return v;
    return (v >> m) | (v << (32 - m));
  endfunction

  function automatic logic [31:0] asr32(input logic [31:0] v, input int k);
    logic signed [31:0] t;
    t = v;
    if (k >= 32) return {32{v[31]}};
    return t >>> k;
  endfunction

  // Architectural shifter operand computed with whole shifts.
  task automatic ref_model(input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] rs, input logic ci,
                           output logic [31:0] res, output logic co, output int n);
    int cls, amt, typ, s, k;
    cls = int'(ins[27:25]);
    amt = int'(ins[11:7]);
    typ = int'(ins[6:5]);
    res = a;
    co  = ci;
    n   = 0;
    if (cls == 0 || (cls == 3 && ins[11:4] != 8'd0)) begin
      if (REG_EN && cls == 0 && ins[4]) begin
        s = int'(rs[7:0]);
        if (s != 0) begin
          case (typ)
            0: begin
              n = (s > 32) ? 32 : s;
              if (s < 32) begin res = a << s; co = a[32-s]; end
              else begin res = '0; co = (s == 32) ? a[0] : 1'b0; end
            end
            1: begin
              n = (s > 32) ? 32 : s;
              if (s < 32) begin res = a >> s; co = a[s-1]; end
              else begin res = '0; co = (s == 32) ? a[31] : 1'b0; end
            end
            2: begin
              n = (s > 32) ? 32 : s;
              res = asr32(a, s);
              co  = (s < 32) ? a[s-1] : a[31];
            end
            default: begin
              k = s % 32;
              if (k == 0) co = a[31];
              else begin n = k; res = ror32(a, k); co = res[31]; end
            end
          endcase
        end
      end else begin
        case (typ)
          0: if (amt != 0) begin res = a << amt; co = a[32-amt]; n = amt; end
          1: if (amt == 0) begin res = '0; co = a[31]; end
             else begin res = a >> amt; co = a[amt-1]; n = amt; end
          2: if (amt == 0) begin res = {32{a[31]}}; co = a[31]; end
             else begin res = asr32(a, amt); co = a[amt-1]; n = amt; end
          default: if (amt == 0) begin res = {ci, a[31:1]}; co = a[0]; n = 1; end
                   else begin res = ror32(a, amt); co = res[31]; n = amt; end
        endcase
      end
    end else if (cls == 1) begin
      k   = 2 * int'(ins[11:8]);
      res = ror32({24'b0, ins[7:0]}, k);
      co  = (k == 0) ? ci : res[31];
      n   = k;
    end else if (cls == 2) begin
      res = {20'b0, ins[11:0]};
    end
  endtask

  // One request through both instances; optional ignored restart at restart_cyc.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] rs, input logic ci, input int restart_cyc);
    logic [31:0] eres, r1, r4;
    logic        eco, c1, c4;
    int          en, le1, le4, lat1, lat4, nd1, nd4, bb1, bb4;
    op_id++;
    ref_model(ins, a, rs, ci, eres, eco, en);
    le1 = 2 + en;
    le4 = 2 + (en + 3) / 4;
    lat1 = 0; lat4 = 0; nd1 = 0; nd4 = 0; bb1 = 0; bb4 = 0;
    r1 = '0; r4 = '0; c1 = 1'b0; c4 = 1'b0;
    instr = ins; rm_val = a; rs_val = rs; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= le1 + 3; cyc++) begin
      if (done1) begin
        nd1++;
        if (lat1 == 0) begin lat1 = cyc; r1 = res1; c1 = cout1; end
      end
      if (done4) begin
        nd4++;
        if (lat4 == 0) begin lat4 = cyc; r4 = res4; c4 = cout4; end
      end
      if (busy1 !== (cyc <= le1)) bb1++;
      if (busy4 !== (cyc <= le4)) bb4++;
      if (cyc == restart_cyc && cyc < le4) begin
        start = 1'b1; instr = $urandom; rm_val = $urandom; cin = ~ci;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("lat_s1",   lat1, le1);
    chk("res_s1",   r1,   eres);
    chk("cout_s1",  c1,   eco);
    chk("ndone_s1", nd1,  1);
    chk("busy_s1",  bb1,  0);
    chk("hold_s1",  res1, eres);
    chk("lat_s4",   lat4, le4);
    chk("res_s4",   r4,   eres);
    chk("cout_s4",  c4,   eco);
    chk("ndone_s4", nd4,  1);
    chk("busy_s4",  bb4,  0);
    chk("hold_s4",  res4, eres);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start = 1'b0; instr = '0; rm_val = '0; rs_val = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {busy1, busy4}, 2'b00);
    chk("rst_done", {done1, done4}, 2'b00);
    chk("rst_res",  {res1, res4}, 64'd0);
    chk("rst_cout", {cout1, cout4}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(32'h0000_0200, 32'h8000_000F, 32'd0, 1'b0, 0);   // LSL #4
    chk("lsl4_res", res1, 32'h0000_00F0);
    chk("lsl4_cout", cout1, 1'b0);
    run_op(32'h0000_0040, 32'h8000_0001, 32'd0, 1'b0, 0);   // ASR #0
    chk("asr0_res", res4, 32'hFFFF_FFFF);
    chk("asr0_cout", cout4, 1'b1);
    run_op(32'h0000_0060, 32'h0000_0003, 32'd0, 1'b1, 0);   // RRX
    chk("rrx_res", res1, 32'h8000_0001);
    chk("rrx_cout", cout1, 1'b1);
    run_op(32'h0200_04FF, 32'h1234_5678, 32'd0, 1'b0, 0);   // imm rotate by 8
    chk("rot_res", res4, 32'hFF00_0000);
    chk("rot_cout", cout4, 1'b1);
    run_op(32'h0000_0020, 32'hC000_0000, 32'd0, 1'b0, 0);   // LSR #0
    run_op(32'h0200_00AB, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);   // imm, no rotate
    run_op(32'h0400_0ABC, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);   // 12-bit offset
    run_op(32'h0600_0000, 32'hDEAD_BEEF, 32'd0, 1'b1, 0);   // 011, [11:4]=0
    run_op(32'h0000_02E0, 32'h0000_00F1, 32'd0, 1'b0, 0);   // ROR #5
    run_op(32'h0000_0A00, 32'h1234_5678, 32'd0, 1'b1, 3);   // LSL #20, start ignored
`ifdef SHIFT_BY_REG_EN
    run_op(32'h0000_0010, 32'h0000_0001, 32'd32, 1'b0, 0);
    chk("reg32_res", res1, 32'd0);
    chk("reg32_cout", cout1, 1'b1);
    run_op(32'h0000_0010, 32'h0000_0001, 32'd40, 1'b0, 0);
    chk("reg40_res", res4, 32'd0);
    chk("reg40_cout", cout4, 1'b0);
`endif

    // Randomized requests
    for (int k = 0; k < 150; k++) begin
      logic [31:0] ins;
      logic [31:0] rs;
      int          sel;
      ins = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4)       ins[27:25] = 3'b000;
      else if (sel < 6)  ins[27:25] = 3'b001;
      else if (sel == 6) ins[27:25] = 3'b011;
      else if (sel == 7) ins[27:25] = 3'b010;
      rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      run_op(ins, $urandom, rs, 1'($urandom),
             ($urandom_range(0, 5) == 0) ? 3 : 0);
    end

    // Abort mid-SHIFT: ROR #30 then asynchronous reset
    op_id++;
    instr = 32'h0000_0F60; rm_val = 32'hA5A5_0F0F; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {busy1, busy4}, 2'b00);
    chk("abort_done", {done1, done4}, 2'b00);
    chk("abort_res",  {res1, res4}, 64'd0);
    chk("abort_cout", {cout1, cout4}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done1 || done4) nd++;
    end
    chk("abort_nodone", nd, 0);
    chk("abort_hold", {res1, res4}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the shifter-operand datapath for ARM data-processing and load/store instructions.
- Decodes shifter_op from the instruction word, loads a shift count, then iterates the shift STEP bits per cycle.
- Returns the 32-bit operand and shifter carry-out with a start/busy/done handshake.
- Sits between the ID/EX pipeline register and the ALU B-operand mux; the control unit stalls on busy.

Parameters:
- STEP, 1, bits shifted per SHIFT cycle; legal values are 1, 2, 4, 8.
- CNT_W, 6, width of the internal shift counter; holds 0..32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- instr  in  32  instruction word B; uses [27:25], [11:0], [6:5], [4].
- rm_val  in  32  operand A (Rm, or the base value).
- rs_val  in  32  Rs value; used only with SHIFT_BY_REG_EN.
- cin  in  1  current CPSR C flag.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result and cout are valid.
- result  out  32  shifter operand; held until the next accepted start.
- cout  out  1  shifter carry-out; held with result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, cout=0; counter cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE -> LOAD -> SHIFT (0..n cycles) -> DONE -> IDLE.
- IDLE: start=1 latches instr, rm_val, rs_val and cin, then moves to LOAD.
- LOAD: decodes the operation, loads the working register and the count n.
  - n=0 goes directly to DONE.
  - Otherwise goes to SHIFT.
- SHIFT: each cycle shifts by min(STEP, remaining) and decrements remaining by the same amount. Leaves for DONE when remaining reaches 0.
- DONE: done=1 for exactly one cycle; result and cout update in this same cycle. busy drops on the DONE->IDLE edge.
- Latency: start to done = 2 + ceil(n/STEP) cycles.
- start in a non-IDLE state is ignored; no queueing.
- Decode for instr[27:25]=000, or 011 with instr[11:4]!=0 (immediate-shift form):
  - amt=instr[11:7]; type=instr[6:5].
  - LSL #0: result=A, cout=cin, n=0.
  - LSL #k: cout=A[32-k].
  - LSR #0: means LSR #32; result=0, cout=A[31].
  - LSR #k: cout=A[k-1].
  - ASR #0: means #32; result={32{A[31]}}, cout=A[31].
  - ASR #k: sign fill, cout=A[k-1].
  - ROR #0: RRX; result={cin,A[31:1]}, cout=A[0], n=1.
  - ROR #k: cout=result[31].
- Decode for 001 (32-bit immediate):
  - Working register = {24'b0, instr[7:0]}; n = 2*instr[11:8]; rotate right.
  - cout = cin if instr[11:8]=0, else result[31].
- Decode for 010: result={20'b0, instr[11:0]}, cout=cin, n=0.
- Decode for 011 with instr[11:4]=0: result=A, cout=cin, n=0.
- Any other instr[27:25]: result=A, cout=cin, n=0.
- Carry during iteration: cout is tracked as the last bit shifted out, so the final value is the architectural carry.

Optional Feature:
- Macro: SHIFT_BY_REG_EN.
- Defined: instr[27:25]=000 with instr[4]=1 takes the shift amount from rs_val[7:0] (0..255).
  - amt=0: result=A, cout=cin.
  - LSL/LSR by 32: result=0; cout=A[0] for LSL, A[31] for LSR.
  - LSL/LSR by more than 32: result=0, cout=0.
  - ASR by 32 or more: result and cout equal to A[31] fill.
  - ROR: amount taken mod 32. If that is 0 and amt!=0: result=A, cout=A[31].
  - Iteration is capped at n=32.
- Not defined: instr[4] is ignored and rs_val is unused; the immediate-shift decode applies.

Test Plan:
- LSL #4, STEP=1: rm_val=0x8000000F, instr=0x00000200, start pulse -> done 6 cycles after start; result=0x000000F0, cout=0; busy high for cycles 1..6.
- ASR #0: rm_val=0x80000001, instr=0x00000040 -> n=0, done at cycle 2; result=0xFFFFFFFF, cout=1.
- RRX: rm_val=0x00000003, instr=0x00000060, cin=1 -> result=0x80000001, cout=1.
- Immediate rotate, STEP=4: instr=0x020004FF -> n=8, done at cycle 4; result=0xFF000000, cout=1.
- Abort and ignored start: start asserted again during SHIFT is ignored (result unchanged, no extra done). Then rst_n=0 mid-SHIFT -> busy=0, done=0, result=0 immediately, with no done pulse after reset is released.
- SHIFT_BY_REG_EN defined: instr=0x00000010, rm_val=0x00000001:
  - rs_val=32 -> result=0, cout=1.
  - rs_val=40 -> result=0, cout=0.
